// File: rtl/bsg_manycore_fam_pair.sv
// Shared multiply-accumulate unit for two adjacent tiles: per-port input FIFOs,
// round-robin issue, fixed-latency pipeline. Optional counters: BSG_FAM_PERF_CNT_EN.
module bsg_manycore_fam_pair #(
    parameter int operand_width_p  = 32,
    parameter int in_data_width_p  = 3 * operand_width_p,
    parameter int out_data_width_p = operand_width_p,
    parameter int num_fifo_p       = 2,
    parameter int num_pipe_p       = 3
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic [1:0]                       v_i,
    input  logic [1:0][in_data_width_p-1:0]  data_i,
    output logic [1:0]                       ready_o,
    output logic [1:0]                       v_o,
    output logic [1:0][out_data_width_p-1:0] data_o
`ifdef BSG_FAM_PERF_CNT_EN
    ,output logic [1:0][31:0]                issue_count_o
    ,output logic [31:0]                     conflict_count_o
`endif
);

    localparam int ptr_w_lp = (num_fifo_p > 1) ? $clog2(num_fifo_p) : 1;
    localparam int cnt_w_lp = $clog2(num_fifo_p + 1);

    logic [in_data_width_p-1:0] mem_r [2][num_fifo_p];
    logic [ptr_w_lp-1:0]        wptr_r [2];
    logic [ptr_w_lp-1:0]        rptr_r [2];
    logic [cnt_w_lp-1:0]        cnt_r  [2];
    logic [1:0]                 full_s;
    logic [1:0]                 nonempty_s;
    logic [1:0]                 enq_s;
    logic [1:0]                 deq_s;
    logic                       prio_r;
    logic                       issue_v_s;
    logic                       issue_tag_s;
    logic [in_data_width_p-1:0] head_s;
    logic [operand_width_p-1:0] op_a_s;
    logic [operand_width_p-1:0] op_b_s;
    logic [operand_width_p-1:0] op_c_s;
    logic [operand_width_p-1:0] issue_res_s;
    logic [num_pipe_p-1:0]      pv_r;
    logic [num_pipe_p-1:0]      ptag_r;
    logic [operand_width_p-1:0] pres_r [num_pipe_p];
    logic [operand_width_p-1:0] hold_r [2];

    // FIFO status; ready is forced low while reset is held
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            full_s[k]     = (cnt_r[k] == cnt_w_lp'(num_fifo_p));
            nonempty_s[k] = (cnt_r[k] != {cnt_w_lp{1'b0}});
        end
        ready_o = ~full_s & {2{~reset_i}};
        enq_s   = v_i & ready_o;
    end

    // Round-robin arbitration: prio_r names the port that wins a tie
    always_comb begin
        issue_v_s = |nonempty_s;
        if (nonempty_s == 2'b11) begin
            issue_tag_s = prio_r;
        end else if (nonempty_s[1]) begin
            issue_tag_s = 1'b1;
        end else begin
            issue_tag_s = 1'b0;
        end
        deq_s = 2'b00;
        if (issue_v_s) begin
            deq_s[issue_tag_s] = 1'b1;
        end else begin
            deq_s = 2'b00;
        end
    end

    // Operand extraction and low-bits multiply-add of the issuing head
    always_comb begin
        head_s      = mem_r[issue_tag_s][rptr_r[issue_tag_s]];
        op_a_s      = head_s[3*operand_width_p-1 -: operand_width_p];
        op_b_s      = head_s[2*operand_width_p-1 -: operand_width_p];
        op_c_s      = head_s[operand_width_p-1:0];
        issue_res_s = op_a_s * op_b_s + op_c_s;
    end

    // FIFO storage; contents need no reset since occupancy gates every read
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < 2; k++) begin
            if (enq_s[k]) begin
                mem_r[k][wptr_r[k]] <= data_i[k];
            end
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < 2; k++) begin
            if (reset_i) begin
                wptr_r[k] <= {ptr_w_lp{1'b0}};
                rptr_r[k] <= {ptr_w_lp{1'b0}};
                cnt_r[k]  <= {cnt_w_lp{1'b0}};
            end else begin
                if (enq_s[k]) begin
                    wptr_r[k] <= (wptr_r[k] == ptr_w_lp'(num_fifo_p - 1)) ? {ptr_w_lp{1'b0}}
                                                                          : wptr_r[k] + ptr_w_lp'(1);
                end
                if (deq_s[k]) begin
                    rptr_r[k] <= (rptr_r[k] == ptr_w_lp'(num_fifo_p - 1)) ? {ptr_w_lp{1'b0}}
                                                                          : rptr_r[k] + ptr_w_lp'(1);
                end
                case ({enq_s[k], deq_s[k]})
                    2'b10:   cnt_r[k] <= cnt_r[k] + cnt_w_lp'(1);
                    2'b01:   cnt_r[k] <= cnt_r[k] - cnt_w_lp'(1);
                    default: cnt_r[k] <= cnt_r[k];
                endcase
            end
        end
    end

    // Priority pointer moves to the other port only when something issues
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            prio_r <= 1'b0;
        end else if (issue_v_s) begin
            prio_r <= ~issue_tag_s;
        end else begin
            prio_r <= prio_r;
        end
    end

    // Non-stalling pipeline; the last stage drives v_o directly
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pv_r   <= {num_pipe_p{1'b0}};
            ptag_r <= {num_pipe_p{1'b0}};
            for (int s = 0; s < num_pipe_p; s++) begin
                pres_r[s] <= {operand_width_p{1'b0}};
            end
        end else begin
            pv_r[0]   <= issue_v_s;
            ptag_r[0] <= issue_tag_s;
            pres_r[0] <= issue_res_s;
            for (int s = 1; s < num_pipe_p; s++) begin
                pv_r[s]   <= pv_r[s-1];
                ptag_r[s] <= ptag_r[s-1];
                pres_r[s] <= pres_r[s-1];
            end
        end
    end

    // Per-port result hold so data_o keeps its last value between pulses
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < 2; k++) begin
            if (reset_i) begin
                hold_r[k] <= {operand_width_p{1'b0}};
            end else if (v_o[k]) begin
                hold_r[k] <= pres_r[num_pipe_p-1];
            end else begin
                hold_r[k] <= hold_r[k];
            end
        end
    end

    // Output steering by the tag of the last pipeline stage
    always_comb begin
        v_o[0] = pv_r[num_pipe_p-1] & ~ptag_r[num_pipe_p-1];
        v_o[1] = pv_r[num_pipe_p-1] &  ptag_r[num_pipe_p-1];
        for (int k = 0; k < 2; k++) begin
            if (v_o[k]) begin
                data_o[k] = out_data_width_p'(pres_r[num_pipe_p-1]);
            end else begin
                data_o[k] = out_data_width_p'(hold_r[k]);
            end
        end
    end

`ifdef BSG_FAM_PERF_CNT_EN
    logic [31:0] issue_cnt_r [2];
    logic [31:0] conflict_cnt_r;

    // Issue and contention counters, free-running with wraparound
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            issue_cnt_r[0] <= 32'd0;
            issue_cnt_r[1] <= 32'd0;
            conflict_cnt_r <= 32'd0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (issue_v_s && (issue_tag_s == k[0])) begin
                    issue_cnt_r[k] <= issue_cnt_r[k] + 32'd1;
                end else begin
                    issue_cnt_r[k] <= issue_cnt_r[k];
                end
            end
            if (nonempty_s == 2'b11) begin
                conflict_cnt_r <= conflict_cnt_r + 32'd1;
            end else begin
                conflict_cnt_r <= conflict_cnt_r;
            end
        end
    end

    assign issue_count_o[0]  = issue_cnt_r[0];
    assign issue_count_o[1]  = issue_cnt_r[1];
    assign conflict_count_o  = conflict_cnt_r;
`endif

endmodule

// File: tb/tb_bsg_manycore_fam_pair.sv
// Scoreboard bench for bsg_manycore_fam_pair: senders push expected results,
// an independent monitor pops and compares whenever v_o pulses.
module tb_bsg_manycore_fam_pair;

    typedef struct {
        logic [31:0] d;
        int          due;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset_i = 1'b1;
    logic              v0 = 1'b0, v1 = 1'b0;
    logic [95:0]       d0 = '0, d1 = '0;
    logic [1:0]        v_i;
    logic [1:0][95:0]  data_i;
    logic [1:0]        ready_o;
    logic [1:0]        v_o;
    logic [1:0][31:0]  data_o;
`ifdef BSG_FAM_PERF_CNT_EN
    logic [1:0][31:0]  issue_count;
    logic [31:0]       conflict_count;
`endif

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   pulse_cnt = 0;
    bit   saw_notready0 = 1'b0, saw_notready1 = 1'b0;
    exp_t exp_q0[$];
    exp_t exp_q1[$];
    int   obs_port_q[$];

    assign v_i    = {v1, v0};
    assign data_i = {d1, d0};

    bsg_manycore_fam_pair dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .v_i     (v_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .v_o     (v_o),
        .data_o  (data_o)
`ifdef BSG_FAM_PERF_CNT_EN
        ,.issue_count_o    (issue_count)
        ,.conflict_count_o (conflict_count)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [95:0] pack(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return {a, b, c};
    endfunction

    // Monitor: pops the scoreboard on every result pulse
    always @(negedge clk) begin
        if (!reset_i) begin
            if (!ready_o[0]) saw_notready0 = 1'b1;
            if (!ready_o[1]) saw_notready1 = 1'b1;
            if (v_o != 2'b00) begin
                pulse_cnt++;
                check("onehot_v_o", {63'd0, (v_o == 2'b11)}, 64'd0);
            end
            for (int k = 0; k < 2; k++) begin
                if (v_o[k]) begin
                    exp_t e;
                    obs_port_q.push_back(k);
                    if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_result port%0d: got %0h expected none", k, data_o[k]);
                    end else begin
                        e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        check($sformatf("data_port%0d", k), {32'd0, data_o[k]}, {32'd0, e.d});
                        if (e.due >= 0) check($sformatf("latency_port%0d", k), 64'(cyc), 64'(e.due));
                    end
                end
            end
        end
    end

    // Holds v_i on a port until accepted; expected result queued on acceptance
    task automatic send(input int p, input logic [95:0] pkt, input logic [31:0] expd, input bit chk_lat);
        int   guard = 0;
        bit   done = 1'b0;
        exp_t e;
        if (p == 0) begin v0 = 1'b1; d0 = pkt; end else begin v1 = 1'b1; d1 = pkt; end
        while (!done) begin
            @(negedge clk);
            if (ready_o[p]) begin
                e.d   = expd;
                e.due = chk_lat ? cyc + 4 : -1;
                if (p == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
                done = 1'b1;
            end else begin
                guard++;
                if (guard > 100) begin
                    checks++;
                    failures++;
                    $display("FAIL send_timeout port%0d: got ready=0 expected ready=1", p);
                    done = 1'b1;
                end
            end
            @(posedge clk); #1;
        end
        if (p == 0) v0 = 1'b0; else v1 = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_q0", 64'(exp_q0.size()), 64'd0);
        check("drain_q1", 64'(exp_q1.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    logic [95:0] p0_tab [5];
    logic [31:0] r0_tab [5];
    logic [95:0] p1_tab [5];
    logic [31:0] r1_tab [5];
    int          snap;

    initial begin
        p0_tab[0] = pack(32'd1, 32'd2, 32'd3);   r0_tab[0] = 32'd5;
        p0_tab[1] = pack(32'd2, 32'd3, 32'd4);   r0_tab[1] = 32'd10;
        p0_tab[2] = pack(32'd3, 32'd4, 32'd5);   r0_tab[2] = 32'd17;
        p0_tab[3] = pack(32'd4, 32'd5, 32'd6);   r0_tab[3] = 32'd26;
        p0_tab[4] = pack(32'd5, 32'd6, 32'd7);   r0_tab[4] = 32'd37;
        p1_tab[0] = pack(32'd10, 32'd10, 32'd1); r1_tab[0] = 32'd101;
        p1_tab[1] = pack(32'd11, 32'd11, 32'd2); r1_tab[1] = 32'd123;
        p1_tab[2] = pack(32'd12, 32'd12, 32'd3); r1_tab[2] = 32'd147;
        p1_tab[3] = pack(32'd13, 32'd13, 32'd4); r1_tab[3] = 32'd173;
        p1_tab[4] = pack(32'd14, 32'd14, 32'd5); r1_tab[4] = 32'd201;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", {62'd0, ready_o}, 64'd0);
        check("reset_v_o", {62'd0, v_o}, 64'd0);
        check("reset_data_o", {data_o[1], data_o[0]}, 64'd0);
        @(posedge clk); #1;
        reset_i = 1'b0;
        @(negedge clk);
        check("ready_after_reset", {62'd0, ready_o}, 64'd3);
        @(posedge clk); #1;

        // Single op with exact latency, then result hold
        send(0, pack(32'd3, 32'd5, 32'd7), 32'd22, 1'b1);
        drain();
        check("hold_data0", {32'd0, data_o[0]}, 64'd22);

        // Wraparound on port 1
        send(1, pack(32'hFFFF_FFFF, 32'd2, 32'd1), 32'hFFFF_FFFF, 1'b1);
        drain();

        // Back-to-back ops on port 0
        send(0, pack(32'd2, 32'd2, 32'd2), 32'd6, 1'b1);
        send(0, pack(32'd7, 32'd8, 32'd9), 32'd65, 1'b1);
        send(0, pack(32'd100, 32'd3, 32'd0), 32'd300, 1'b1);
        drain();

        // Reset with two ops in flight and one queued
        for (int i = 0; i < 3; i++) begin
            v0 = 1'b1;
            d0 = pack(32'd9, 32'd9, 32'(i));
            @(posedge clk); #1;
        end
        v0 = 1'b0;
        reset_i = 1'b1;
        snap = pulse_cnt;
        @(posedge clk); #1;
        reset_i = 1'b0;
        @(negedge clk);
        check("ready_after_midreset", {62'd0, ready_o}, 64'd3);
        repeat (10) @(posedge clk);
        #1;
        check("no_pulse_after_reset", 64'(pulse_cnt - snap), 64'd0);

        // Contention: both ports saturated
        obs_port_q.delete();
        saw_notready0 = 1'b0;
        saw_notready1 = 1'b0;
        fork
            for (int i = 0; i < 5; i++) send(0, p0_tab[i], r0_tab[i], 1'b0);
            for (int j = 0; j < 5; j++) send(1, p1_tab[j], r1_tab[j], 1'b0);
        join
        drain();
        check("contention_count", 64'(obs_port_q.size()), 64'd10);
        for (int i = 0; i < obs_port_q.size(); i++)
            check($sformatf("issue_order_%0d", i), 64'(obs_port_q[i]), 64'(i % 2));
        check("full_seen_port0", {63'd0, saw_notready0}, 64'd1);
        check("full_seen_port1", {63'd0, saw_notready1}, 64'd1);
`ifdef BSG_FAM_PERF_CNT_EN
        check("issue_count0", {32'd0, issue_count[0]}, 64'd5);
        check("issue_count1", {32'd0, issue_count[1]}, 64'd5);
        check("conflict_nonzero", {63'd0, (conflict_count != 32'd0)}, 64'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
